// File: rtl/ppg_pkg.sv
// Shared definitions for the burst pulse generator: state encoding and
// default widths used by the sequencer and the per-channel slices.
package ppg_pkg;

  localparam int PPG_WIDTH_DEF = 16;
  localparam int PPG_NCH_DEF   = 4;
  localparam int PPG_RPT_W_DEF = 8;

  typedef enum logic {
    PPG_IDLE = 1'b0,
    PPG_RUN  = 1'b1
  } ppg_state_e;

endpackage

// File: rtl/ppg_chan.sv
// One output channel: compares the in-frame offset against this channel's
// lead/hold window and registers the polarity-adjusted result.
module ppg_chan
  import ppg_pkg::*;
#(
  parameter int WIDTH = PPG_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] off,
  input  logic             run,
  input  logic [WIDTH-1:0] lead,
  input  logic [WIDTH-1:0] hold,
  input  logic             pol,
  output logic             q
);

  logic [WIDTH:0] stop;
  logic           act;

  // NOTE: the window end is formed one bit wider so lead+hold never wraps
  // back into the frame and creates a spurious early pulse.
  assign stop = {1'b0, lead} + {1'b0, hold};
  assign act  = run && (lead <= off) && ({1'b0, off} < stop);

  // Output register: idle level XOR window hit, cleared to 0 by reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q <= 1'b0;
    else       q <= pol ^ act;
  end

endmodule

// File: rtl/ppg_burst.sv
// Multi-channel burst pulse generator. A trigger latches the timing
// configuration and runs n_rpt+1 frames of t_period cycles; each channel
// pulses once per frame inside its own lead/hold window.
module ppg_burst
  import ppg_pkg::*;
#(
  parameter int WIDTH = PPG_WIDTH_DEF,
  parameter int NCH   = PPG_NCH_DEF,
  parameter int RPT_W = PPG_RPT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 trig,
  input  logic                 abort,
  input  logic                 retrig_en,
  input  logic [WIDTH-1:0]     t_period,
  input  logic [RPT_W-1:0]     n_rpt,
  input  logic [NCH*WIDTH-1:0] t_lead,
  input  logic [NCH*WIDTH-1:0] t_hold,
  input  logic [NCH-1:0]       pol,
  output logic [NCH-1:0]       q,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  ppg_state_e           state;
  logic [WIDTH-1:0]     off;
  logic [RPT_W-1:0]     frm;
  logic [WIDTH-1:0]     per_l;
  logic [RPT_W-1:0]     rpt_l;
  logic [NCH*WIDTH-1:0] lead_l;
  logic [NCH*WIDTH-1:0] hold_l;
  logic [NCH-1:0]       pol_l;

  logic                 launch;
  logic                 last_off;
  logic [WIDTH-1:0]     per_in;
  logic                 chan_run;
  logic [NCH-1:0]       chan_pol;

  assign busy     = (state == PPG_RUN);
  // Abort has priority; otherwise trig starts from IDLE, or restarts when
  // retriggering is enabled.
  assign launch   = trig && !abort && ((state == PPG_IDLE) || retrig_en);
  assign last_off = (off == per_l - WIDTH'(1));
  assign per_in   = (t_period == '0) ? WIDTH'(1) : t_period;

  // Channels see the frozen polarity only while running; when idle (or on
  // the abort edge) they follow the live pol input so the idle level tracks
  // software configuration without waiting for a launch.
  assign chan_run = (state == PPG_RUN) && !abort;
  assign chan_pol = chan_run ? pol_l : pol;

  // Sequencer: state, frame offset/count, configuration latches, pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= PPG_IDLE;
      off     <= '0;
      frm     <= '0;
      per_l   <= '0;
      rpt_l   <= '0;
      lead_l  <= '0;
      hold_l  <= '0;
      pol_l   <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      if (abort) begin
        state <= PPG_IDLE;
        off   <= '0;
        frm   <= '0;
      end else if (launch) begin
        state  <= PPG_RUN;
        off    <= '0;
        frm    <= '0;
        per_l  <= per_in;
        rpt_l  <= n_rpt;
        lead_l <= t_lead;
        hold_l <= t_hold;
        pol_l  <= pol;
      end else if (state == PPG_RUN) begin
        if (trig) overrun <= 1'b1;
        if (last_off) begin
          off <= '0;
          if (frm == rpt_l) begin
            state <= PPG_IDLE;
            frm   <= '0;
            done  <= 1'b1;
          end else begin
            frm <= frm + RPT_W'(1);
          end
        end else begin
          off <= off + WIDTH'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    ppg_chan #(.WIDTH(WIDTH)) u_chan (
      .clk  (clk),
      .rstn (rstn),
      .off  (off),
      .run  (chan_run),
      .lead (lead_l[i*WIDTH +: WIDTH]),
      .hold (hold_l[i*WIDTH +: WIDTH]),
      .pol  (chan_pol[i]),
      .q    (q[i])
    );
  end

endmodule

// File: tb/tb_ppg_burst.sv
// Directed bench for ppg_burst with two channels. Edge Ek is the k-th clock
// edge after the launch edge E0; outputs are sampled 1 time unit after it.
module tb_ppg_burst;

  localparam int WIDTH = 16;
  localparam int NCH   = 2;
  localparam int RPT_W = 8;

  logic                 clk;
  logic                 rstn;
  logic                 trig;
  logic                 abort;
  logic                 retrig_en;
  logic [WIDTH-1:0]     t_period;
  logic [RPT_W-1:0]     n_rpt;
  logic [NCH*WIDTH-1:0] t_lead;
  logic [NCH*WIDTH-1:0] t_hold;
  logic [NCH-1:0]       pol;
  logic [NCH-1:0]       q;
  logic                 busy;
  logic                 done;
  logic                 overrun;

  int n_checks = 0;
  int n_errs   = 0;

  ppg_burst #(.WIDTH(WIDTH), .NCH(NCH), .RPT_W(RPT_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .trig      (trig),
    .abort     (abort),
    .retrig_en (retrig_en),
    .t_period  (t_period),
    .n_rpt     (n_rpt),
    .t_lead    (t_lead),
    .t_hold    (t_hold),
    .pol       (pol),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int per, input int rpt, input int lead0, input int hold0,
                     input int lead1, input int hold1, input logic [1:0] polv);
    t_period = WIDTH'(per);
    n_rpt    = RPT_W'(rpt);
    t_lead   = {WIDTH'(lead1), WIDTH'(lead0)};
    t_hold   = {WIDTH'(hold1), WIDTH'(hold0)};
    pol      = polv;
  endtask

  // Launch a burst at E0 and check every edge up to end_k+2.
  // act0/act1: bit k set when that channel is active after Ek.
  // end_k: first edge after which busy is low; done_exp: done pulses there.
  // trig_k/abort_k: edge at which an extra trig/abort is sampled (-1 none).
  task automatic burst(input string tag, input int end_k, input bit done_exp,
                       input logic [31:0] act0, input logic [31:0] act1,
                       input logic [31:0] ovr_mask, input int trig_k, input int abort_k);
    logic [1:0] eq;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    check($sformatf("%s E0 busy", tag), 32'(busy), 32'd1);
    check($sformatf("%s E0 q", tag), 32'(q), 32'(pol));
    for (int k = 1; k <= end_k + 2; k++) begin
      trig  = (k == trig_k);
      abort = (k == abort_k);
      tick();
      trig  = 1'b0;
      abort = 1'b0;
      eq = pol ^ {act1[k], act0[k]};
      check($sformatf("%s E%0d q", tag, k), 32'(q), 32'(eq));
      check($sformatf("%s E%0d busy", tag, k), 32'(busy), 32'(k < end_k));
      check($sformatf("%s E%0d done", tag, k), 32'(done), 32'(done_exp && (k == end_k)));
      check($sformatf("%s E%0d overrun", tag, k), 32'(overrun), 32'(ovr_mask[k]));
    end
  endtask

  initial begin
    logic [1:0] eq;
    rstn = 1'b0; trig = 1'b0; abort = 1'b0; retrig_en = 1'b0;
    cfg(0, 0, 0, 0, 0, 0, 2'b11);

    // Reset: q is 0 even with pol=11.
    tick(); tick();
    check("rst q", 32'(q), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst overrun", 32'(overrun), 32'd0);
    rstn = 1'b1;
    tick();
    check("idle q follows pol", 32'(q), 32'b11);
    pol = 2'b00;
    tick();
    check("idle q follows pol 0", 32'(q), 32'b00);

    // Single frame, two channels.
    cfg(10, 0, 2, 3, 0, 1, 2'b00);
    burst("basic", 10, 1'b1, 32'h38, 32'h2, 32'h0, -1, -1);

    // Three frames of 4 cycles: q0 at E2, E6, E10 for 2 cycles each.
    cfg(4, 2, 1, 2, 0, 0, 2'b00);
    burst("rpt", 12, 1'b1, 32'hCCC, 32'h0, 32'h0, -1, -1);

    // Truncation at the frame end, lead past the frame, zero hold.
    cfg(5, 0, 3, 10, 0, 0, 2'b00);
    burst("trunc", 5, 1'b1, 32'h30, 32'h0, 32'h0, -1, -1);
    cfg(5, 0, 7, 10, 0, 0, 2'b00);
    burst("lead_late", 5, 1'b1, 32'h0, 32'h0, 32'h0, -1, -1);
    cfg(5, 0, 3, 0, 0, 0, 2'b00);
    burst("hold0", 5, 1'b1, 32'h0, 32'h0, 32'h0, -1, -1);

    // t_period=0 behaves as 1: two one-cycle frames.
    cfg(0, 1, 0, 1, 0, 0, 2'b00);
    burst("per0", 2, 1'b1, 32'h6, 32'h0, 32'h0, -1, -1);

    // Trig while busy, retriggering disabled then enabled.
    cfg(10, 0, 2, 3, 0, 1, 2'b00);
    retrig_en = 1'b0;
    burst("ovr", 10, 1'b1, 32'h38, 32'h2, 32'h10, 4, -1);
    burst("ovr_last", 10, 1'b1, 32'h38, 32'h2, 32'h400, 10, -1);
    retrig_en = 1'b1;
    burst("retrig", 14, 1'b1, 32'h398, 32'h22, 32'h0, 4, -1);
    burst("retrig_last", 20, 1'b1, 32'hE038, 32'h802, 32'h0, 10, -1);

    // Abort with non-zero idle polarity; abort beats a same-cycle trig.
    cfg(10, 0, 2, 3, 0, 1, 2'b01);
    retrig_en = 1'b0;
    burst("abort", 3, 1'b0, 32'h0, 32'h2, 32'h0, -1, 3);
    retrig_en = 1'b1;
    burst("abort_trig", 3, 1'b0, 32'h0, 32'h2, 32'h0, 3, 3);
    retrig_en = 1'b0;

    // Asynchronous reset mid-burst.
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick(); tick();
    #2;
    rstn = 1'b0;
    #1;
    check("async rst q", 32'(q), 32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("post rst q", 32'(q), 32'b01);
    check("post rst busy", 32'(busy), 32'd0);

    // Live configuration change during RUN does not affect the burst.
    cfg(10, 0, 2, 3, 0, 1, 2'b00);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) begin
        t_hold   = {WIDTH'(0), WIDTH'(7)};
        pol      = 2'b11;
        t_period = WIDTH'(3);
      end
      tick();
      eq[0] = (k >= 3 && k <= 5);
      eq[1] = (k == 1);
      if (k >= 11) eq = 2'b11;
      check($sformatf("live E%0d q", k), 32'(q), 32'(eq));
      check($sformatf("live E%0d busy", k), 32'(busy), 32'(k < 10));
      check($sformatf("live E%0d done", k), 32'(done), 32'(k == 10));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
